// File: rtl/digit_argmax.sv
// digit_argmax: classifier back-end for the MNIST conv pipeline.
// Sums each signed logit channel over all beats of one image, then on the
// frame-end beat scans the sums one channel per cycle with a single shared
// comparator and reports the argmax under a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   conv_din          CHANNELS x N-bit signed logits, channel c at [c*N +: N]
//   conv_din_vld      beat valid
//   conv_din_end      last beat of image (qualified by conv_din_vld)
//   result_class      argmax channel index
//   result_score      signed accumulated score of the winning channel
//   result_vld        result valid, held until result_rdy
//   result_rdy        consumer ready
//   busy              high while scanning or holding a result
//   overrun           one-cycle pulse when an incoming beat is dropped
`timescale 1ns/1ps

module digit_argmax #(
   parameter int unsigned N         = 8,
   parameter int unsigned CHANNELS  = 10,
   parameter int unsigned POSITIONS = 1,
   parameter int unsigned CLASS_W   = 4,
   parameter int unsigned ACC_W     = N + $clog2(POSITIONS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS*N-1:0] conv_din,
   input  logic                  conv_din_vld,
   input  logic                  conv_din_end,
   output logic [CLASS_W-1:0]    result_class,
   output logic [ACC_W-1:0]      result_score,
   output logic                  result_vld,
   input  logic                  result_rdy,
   output logic                  busy,
   output logic                  overrun
);

   // idx runs one past the last channel so the final compare lands in
   // best_* before the result registers are loaded.
   localparam int unsigned IDX_W = $clog2(CHANNELS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q [CHANNELS];
   logic signed [ACC_W-1:0]   acc_d [CHANNELS];
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic signed [ACC_W-1:0]   best_val_q, best_val_d;
   logic [CLASS_W-1:0]        best_idx_q, best_idx_d;
   logic [CLASS_W-1:0]        result_class_q, result_class_d;
   logic [ACC_W-1:0]          result_score_q, result_score_d;
   logic                      result_vld_q, result_vld_d;
   logic                      busy_q, busy_d;
   logic                      overrun_q, overrun_d;

   logic signed [N-1:0]       logit [CHANNELS];
   logic signed [ACC_W-1:0]   cand_c;

   // Unpack the beat into per-channel signed logits.
   always_comb begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         logit[c] = conv_din[c*N +: N];
      end
   end

   // Accumulator currently presented to the shared comparator.
   always_comb begin
      cand_c = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (IDX_W'(c) == idx_q) begin
            cand_c = acc_q[c];
         end
      end
   end

   // Next-state and datapath.
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      best_val_d     = best_val_q;
      best_idx_d     = best_idx_q;
      result_class_d = result_class_q;
      result_score_d = result_score_q;
      result_vld_d   = result_vld_q;
      overrun_d      = 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         acc_d[c] = acc_q[c];
      end

      unique case (state_q)
         S_IDLE: begin
            if (conv_din_vld) begin
               for (int unsigned c = 0; c < CHANNELS; c++) begin
                  acc_d[c] = acc_q[c] + ACC_W'(logit[c]);
               end
               if (conv_din_end) begin
                  state_d = S_SCAN;
                  idx_d   = '0;
               end
            end
         end

         S_SCAN: begin
            overrun_d = conv_din_vld;
            if (idx_q == '0) begin
               best_val_d = cand_c;
               best_idx_d = '0;
            end else if (idx_q < IDX_W'(CHANNELS)) begin
               // Strictly greater: ties keep the lower index.
               if (cand_c > best_val_q) begin
                  best_val_d = cand_c;
                  best_idx_d = CLASS_W'(idx_q);
               end
            end

            if (idx_q == IDX_W'(CHANNELS)) begin
               result_class_d = best_idx_q;
               result_score_d = best_val_q;
               result_vld_d   = 1'b1;
               state_d        = S_DONE;
               for (int unsigned c = 0; c < CHANNELS; c++) begin
                  acc_d[c] = '0;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         S_DONE: begin
            overrun_d = conv_din_vld;
            if (result_vld_q && result_rdy) begin
               result_vld_d = 1'b0;
               state_d      = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         best_val_q     <= '0;
         best_idx_q     <= '0;
         result_class_q <= '0;
         result_score_q <= '0;
         result_vld_q   <= 1'b0;
         busy_q         <= 1'b0;
         overrun_q      <= 1'b0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            acc_q[c] <= '0;
         end
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         best_val_q     <= best_val_d;
         best_idx_q     <= best_idx_d;
         result_class_q <= result_class_d;
         result_score_q <= result_score_d;
         result_vld_q   <= result_vld_d;
         busy_q         <= busy_d;
         overrun_q      <= overrun_d;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            acc_q[c] <= acc_d[c];
         end
      end
   end

   assign result_class = result_class_q;
   assign result_score = result_score_q;
   assign result_vld   = result_vld_q;
   assign busy         = busy_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_digit_argmax.sv
// Bench for digit_argmax: default instance (dut_a) plus a POSITIONS=4
// instance (dut_b) sharing stimulus, selected by sel. Expected results are
// queued when an image is sent and popped when the selected DUT hands over.
`timescale 1ns/1ps

module tb_digit_argmax;

   localparam int unsigned N  = 8;
   localparam int unsigned CH = 10;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH*N-1:0] din = '0;
   logic          vld = 1'b0;
   logic          endb = 1'b0;
   logic          rdy = 1'b1;
   logic          sel = 1'b0;
   logic          vld_a, vld_b;

   logic [CW-1:0] cls_a, cls_b;
   logic [7:0]    score_a;
   logic [9:0]    score_b;
   logic          rv_a, rv_b, busy_a, busy_b, ovr_a, ovr_b;

   always #5 clk = ~clk;

   assign vld_a = vld & ~sel;
   assign vld_b = vld & sel;

   digit_argmax dut_a (
      .clk(clk), .rst_n(rst_n), .conv_din(din), .conv_din_vld(vld_a),
      .conv_din_end(endb), .result_class(cls_a), .result_score(score_a),
      .result_vld(rv_a), .result_rdy(rdy), .busy(busy_a), .overrun(ovr_a));

   digit_argmax #(.POSITIONS(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .conv_din(din), .conv_din_vld(vld_b),
      .conv_din_end(endb), .result_class(cls_b), .result_score(score_b),
      .result_vld(rv_b), .result_rdy(rdy), .busy(busy_b), .overrun(ovr_b));

   typedef struct {
      logic [CH*N-1:0] din;
      int              cls;
      int              score;
   } vec_t;

   typedef struct {
      int cls;
      int score;
   } exp_t;

   exp_t exq[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string nm, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   function automatic logic [CH*N-1:0] pk(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8,
                                          input int a9);
      int v[CH];
      logic [CH*N-1:0] r;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4;
      v[5] = a5; v[6] = a6; v[7] = a7; v[8] = a8; v[9] = a9;
      r = '0;
      for (int c = 0; c < CH; c++) r[c*N +: N] = N'(v[c]);
      return r;
   endfunction

   function automatic logic cur_vld();
      return sel ? rv_b : rv_a;
   endfunction

   function automatic int cur_cls();
      return sel ? int'(cls_b) : int'(cls_a);
   endfunction

   function automatic int cur_score();
      return sel ? int'($signed(score_b)) : int'($signed(score_a));
   endfunction

   function automatic int cur_busy();
      return sel ? int'(busy_b) : int'(busy_a);
   endfunction

   // Scoreboard: compare every accepted result against the queue head.
   always @(negedge clk) begin
      if (rst_n && cur_vld() && rdy) begin
         if (exq.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = exq.pop_front();
            check("result_class", cur_cls(), e.cls);
            check("result_score", cur_score(), e.score);
         end
      end
   end

   task automatic beat(input logic [CH*N-1:0] d, input logic e);
      @(negedge clk);
      din  = d;
      vld  = 1'b1;
      endb = e;
      @(posedge clk);
      #1;
      vld  = 1'b0;
      endb = 1'b0;
   endtask

   // Edges after the end-beat edge until result_vld is seen; -1 on timeout.
   task automatic wait_vld(output int edges);
      bit seen;
      seen  = 1'b0;
      edges = -1;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (cur_vld()) begin
            seen  = 1'b1;
            edges = i - 1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t vecs[5];
   int   lat;
   int   extra;

   initial begin
      vecs[0] = '{pk(3, -5, 12, 7, 0, -128, 11, 12, 1, 2), 2, 12};
      vecs[1] = '{pk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128), 0, -128};
      vecs[2] = '{pk(-1, -2, -3, -4, -5, -6, -7, -8, -9, 127), 9, 127};
      vecs[3] = '{pk(-7, -3, -3, -9, -100, -50, -4, -3, -8, -128), 1, -3};
      vecs[4] = '{pk(0, 0, 0, 0, 127, 0, 0, 0, 127, 0), 4, 127};

      // Reset state
      #12;
      check("rst_vld", int'(rv_a), 0);
      check("rst_busy", int'(busy_a), 0);
      check("rst_class", int'(cls_a), 0);
      check("rst_score", int'(score_a), 0);
      check("rst_overrun", int'(ovr_a), 0);
      check("rst_b_vld", int'(rv_b), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-beat images, result taken immediately
      sel = 1'b0;
      rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exq.push_back('{vecs[i].cls, vecs[i].score});
         beat(vecs[i].din, 1'b1);
         check("busy_after_end", int'(busy_a), 1);
         wait_vld(lat);
         check("latency", lat, CH + 1);
         @(negedge clk);
         check("vld_one_cycle", int'(rv_a), 0);
         check("busy_after_take", int'(busy_a), 0);
      end

      // POSITIONS=4 instance: multi-beat sums, then clean restart
      sel = 1'b1;
      exq.push_back('{9, 508});
      for (int b = 0; b < 4; b++) begin
         beat(pk(100, 100, 100, 100, 100, 100, 100, 100, 100, 127), (b == 3));
      end
      wait_vld(lat);
      check("b_latency", lat, CH + 1);
      @(negedge clk);
      exq.push_back('{0, 0});
      beat('0, 1'b1);
      wait_vld(lat);
      check("b_latency2", lat, CH + 1);
      @(negedge clk);
      check("b_busy_idle", cur_busy(), 0);
      sel = 1'b0;

      // Back-pressure: result held while rdy=0
      rdy = 1'b0;
      exq.push_back('{2, 12});
      beat(vecs[0].din, 1'b1);
      wait_vld(lat);
      check("hold_latency", lat, CH + 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_vld", int'(rv_a), 1);
         check("hold_class", int'(cls_a), 2);
         check("hold_score", int'($signed(score_a)), 12);
         check("hold_busy", int'(busy_a), 1);
      end
      @(posedge clk);
      #1 rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("release_vld", int'(rv_a), 0);
      check("release_busy", int'(busy_a), 0);

      // Overrun during SCAN and during DONE
      rdy = 1'b0;
      exq.push_back('{1, -3});
      beat(vecs[3].din, 1'b1);
      repeat (2) @(posedge clk);
      beat(pk(127, 127, 127, 127, 127, 127, 127, 127, 127, 127), 1'b1);
      check("overrun_scan", int'(ovr_a), 1);
      @(posedge clk);
      #1;
      check("overrun_scan_end", int'(ovr_a), 0);
      wait_vld(lat);
      check("overrun_seen_vld", int'(lat >= 0), 1);
      beat(pk(127, 127, 127, 127, 127, 127, 127, 127, 127, 127), 1'b1);
      check("overrun_done", int'(ovr_a), 1);
      @(posedge clk);
      #1;
      check("overrun_done_end", int'(ovr_a), 0);
      check("done_class_kept", int'(cls_a), 1);
      check("done_score_kept", int'($signed(score_a)), -3);
      rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("overrun_release_vld", int'(rv_a), 0);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (rv_a) extra++;
      end
      check("no_second_result", extra, 0);
      check("no_second_busy", int'(busy_a), 0);

      // Reset mid-scan, then a clean image
      beat(pk(0, 0, 0, 0, 0, 127, 0, 0, 0, 0), 1'b1);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", int'(busy_a), 0);
      check("midrst_vld", int'(rv_a), 0);
      check("midrst_class", int'(cls_a), 0);
      check("midrst_score", int'(score_a), 0);
      check("midrst_overrun", int'(ovr_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      exq.push_back('{1, -3});
      beat(vecs[3].din, 1'b1);
      wait_vld(lat);
      check("post_rst_latency", lat, CH + 1);
      @(negedge clk);
      check("scoreboard_drained", exq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/digit_argmax.md
Name: digit_argmax

Overview:
- Classifier back-end; sits directly downstream of the final depthwise-separable conv stage of the MNIST network.
- Consumes the per-position output-channel logit vectors (signed, N bits per channel) and sums each channel over all spatial positions of one image.
- On the frame-end beat, scans the sums serially and reports the index and value of the largest one.
- Holds the result under a valid/ready handshake until the consumer takes it.

Parameters:
N, 8, bit width of one signed logit.
CHANNELS, 10, number of classes (logit channels per beat).
POSITIONS, 1, maximum beats per image (OUTPUT_SIZE^2 of the last conv stage); sizes the accumulators.
CLASS_W, 4, class index width; must be >= $clog2(CHANNELS).
ACC_W, N+$clog2(POSITIONS), accumulator and score width (8 at defaults).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
conv_din  input  CHANNELS*N  logits; channel c at bits [c*N +: N], two's complement.
conv_din_vld  input  1  beat valid.
conv_din_end  input  1  last beat of image; meaningful only together with conv_din_vld.
result_class  output  CLASS_W  argmax channel index.
result_score  output  ACC_W  signed accumulated score of the winning channel.
result_vld  output  1  result valid; held until accepted.
result_rdy  input  1  consumer ready.
busy  output  1  high in SCAN or DONE.
overrun  output  1  one-cycle pulse when a beat is dropped.

Behaviour:
- Reset (async assert, sync-released by the surrounding system): state=IDLE, all accumulators=0, result_class=0, result_score=0, result_vld=0, busy=0, overrun=0.
- States: IDLE, SCAN, DONE.
- IDLE, beat accepted (conv_din_vld=1):
  - acc[c] <= acc[c] + sign-extended conv_din[c].
  - If conv_din_end=1 on the same beat, the beat is included, then the state goes to SCAN with idx=0.
- conv_din_end=1 without conv_din_vld: ignored.
- SCAN, one channel per cycle, idx = 0..CHANNELS-1:
  - idx=0 loads best_val=acc[0], best_idx=0.
  - Later idx replace best only if acc[idx] > best_val (signed, strictly greater). Ties therefore go to the lowest index.
  - After idx=CHANNELS-1: state goes to DONE, result_class/result_score are registered, result_vld=1, and all accumulators clear to 0 on the same edge.
- Latency: end beat sampled at edge k -> result_vld high after edge k+CHANNELS+1 (11 cycles at defaults).
- DONE:
  - result_vld, result_class and result_score are held stable while result_rdy=0.
  - On result_vld & result_rdy at an edge: result_vld drops, state goes to IDLE.
  - The next beat can be accepted from the following cycle. There is no same-cycle accept-and-restart.
- Overrun:
  - conv_din_vld=1 while in SCAN or DONE: the beat is dropped, overrun=1 for exactly that cycle, accumulators are untouched.
  - A dropped end beat does not start a new scan.
- Accumulation never wraps provided no more than POSITIONS beats arrive per image. Beats beyond POSITIONS are summed modulo 2^ACC_W; this is not checked.
- busy = (state != IDLE), registered.
- Reset mid-SCAN or mid-DONE: everything returns to reset values immediately and any partial result is lost.
- Only CHANNELS-1 compares are used, with a single shared comparator. There is no parallel comparator tree.

Test Plan:
1. Defaults, single beat, end=1, logits c0..c9 = {3,-5,12,7,0,-128,11,12,1,2}, result_rdy=1 -> after 11 cycles result_vld=1 for 1 cycle, result_class=2 (tie with channel 7 resolved low), result_score=12.
2. All logits = -128 -> result_class=0, result_score=-128 (0x80).
3. POSITIONS=4 (ACC_W=10), 4 beats with channel 9 = 127 on every beat and all others 100 -> result_class=9, result_score=508. Next image with all channels 0 -> result_class=0, score=0, confirming accumulators cleared.
4. result_rdy held 0 for 20 cycles after result_vld rises -> outputs stable and busy=1 throughout. Raise rdy -> result_vld falls next edge and busy falls.
5. Second vld+end beat issued 3 cycles after the first end and again during DONE -> overrun pulses once per dropped beat, the first result is unchanged, and no second result appears.
6. Assert rst_n=0 at idx=5 of SCAN -> all outputs 0 asynchronously. After release, a fresh image produces the correct result with no residue from the aborted one.
